// File: rtl/alu_pkg.sv
// Shared ALU operation encoding and execute-stage FSM states, imported by
// alu_exec and the upstream ALU control decoder so both agree on one encoding.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_ctrl_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } alu_state_e;

    function automatic logic is_shift(alu_ctrl_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// One-bit-per-cycle shifter used by alu_exec when ALU_BARREL_SHIFT_EN is not defined.
// o_done/o_result are combinational so the parent can capture the final value on the last shift edge.
module alu_iter_shifter
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  alu_ctrl_e       i_mode,
    input  logic [XLEN-1:0] i_data,
    input  logic [SHW-1:0]  i_shamt,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    logic [XLEN-1:0] r_work;
    logic [SHW-1:0]  r_count;
    alu_ctrl_e       r_mode;
    logic [XLEN-1:0] w_next;

    always_comb begin
        w_next = r_work;
        case (r_mode)
            ALU_SLL: w_next = {r_work[XLEN-2:0], 1'b0};
            ALU_SRL: w_next = {1'b0, r_work[XLEN-1:1]};
            ALU_SRA: w_next = {r_work[XLEN-1], r_work[XLEN-1:1]};
            default: w_next = r_work;
        endcase
    end

    // The counter idles at zero, so the work register only moves while a shift is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work  <= '0;
            r_count <= '0;
            r_mode  <= ALU_SLL;
        end else if (i_start) begin
            r_work  <= i_data;
            r_count <= i_shamt;
            r_mode  <= i_mode;
        end else if (r_count != '0) begin
            r_work  <= w_next;
            r_count <= r_count - SHW'(1);
        end
    end

    assign o_done   = (r_count == SHW'(1));
    assign o_result = w_next;

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready on both sides and a registered result/zero/illegal_op.
// Shifts are iterative by default; defining ALU_BARREL_SHIFT_EN makes them single-cycle.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal_op
);

    localparam int SHW = $clog2(XLEN);

    alu_ctrl_e       w_op;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_aluResult;
    logic            w_illegal;
    logic            w_outFree;
    logic            w_accept;

    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_outValid;
    logic            r_illegal;

    assign w_op      = alu_ctrl_e'(alu_ctrl);
    assign w_shamt   = op_b[SHW-1:0];
    assign w_outFree = !r_outValid || out_ready;

    always_comb begin
        w_aluResult = '0;
        w_illegal   = 1'b0;
        case (w_op)
            ALU_ADD:  w_aluResult = op_a + op_b;
            ALU_SUB:  w_aluResult = op_a - op_b;
            ALU_AND:  w_aluResult = op_a & op_b;
            ALU_OR:   w_aluResult = op_a | op_b;
            ALU_XOR:  w_aluResult = op_a ^ op_b;
            ALU_SLT:  w_aluResult = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: w_aluResult = {{(XLEN-1){1'b0}}, op_a < op_b};
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL:  w_aluResult = op_a << w_shamt;
            ALU_SRL:  w_aluResult = op_a >> w_shamt;
            ALU_SRA:  w_aluResult = $signed(op_a) >>> w_shamt;
`else
            // Only a zero shift amount takes the single-cycle path; the rest go to the shifter.
            ALU_SLL, ALU_SRL, ALU_SRA: w_aluResult = op_a;
`endif
            default: begin
                w_aluResult = '0;
                w_illegal   = 1'b1;
            end
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN

    assign in_ready = w_outFree;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_outValid <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_accept) begin
            r_result   <= w_aluResult;
            r_zero     <= (w_aluResult == '0);
            r_illegal  <= w_illegal;
            r_outValid <= 1'b1;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

`else

    alu_state_e      r_state;
    logic            w_shStart;
    logic            w_shDone;
    logic [XLEN-1:0] w_shResult;

    assign in_ready  = (r_state == IDLE) && w_outFree;
    assign w_accept  = in_valid && in_ready;
    assign w_shStart = w_accept && is_shift(w_op) && (w_shamt != '0);

    alu_iter_shifter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_shStart),
        .i_mode   (w_op),
        .i_data   (op_a),
        .i_shamt  (w_shamt),
        .o_done   (w_shDone),
        .o_result (w_shResult)
    );

    // A consumed result drops out_valid unless a new result lands on the same edge below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_outValid <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            if (out_ready) begin
                r_outValid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_shStart) begin
                        r_state <= SHIFT;
                    end else if (w_accept) begin
                        r_result   <= w_aluResult;
                        r_zero     <= (w_aluResult == '0);
                        r_illegal  <= w_illegal;
                        r_outValid <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_shDone) begin
                        r_result   <= w_shResult;
                        r_zero     <= (w_shResult == '0);
                        r_illegal  <= 1'b0;
                        r_outValid <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`endif

    assign result     = r_result;
    assign zero       = r_zero;
    assign out_valid  = r_outValid;
    assign illegal_op = r_illegal;

endmodule
